// File: rtl/wam_score_bcd.sv
// Multi-digit BCD score accumulator for the Whac-A-Mole datapath: multi-hit add with clamp,
// miss decrement with floor, level-up pulse and high-score register.
module wam_score_bcd #(
    parameter int unsigned NCH       = 8,
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned LVL_DIGIT = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [NCH-1:0]        hit,
    input  logic                  miss,
    input  logic                  game_end,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hiscore,
    output logic                  level_up,
    output logic                  sat,
    output logic                  new_hi
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] MaxScore = {DIGITS{4'h9}};
    localparam logic [DIGITS:0] LvlMask = {{DIGITS{1'b0}}, 1'b1} << LVL_DIGIT;

    if (NCH < 1 || NCH > 9) begin : g_bad_nch
        $error("wam_score_bcd: NCH must be 1..9");
    end
    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
        $error("wam_score_bcd: DIGITS must be 1..6");
    end
    if (LVL_DIGIT >= DIGITS) begin : g_bad_lvl
        $error("wam_score_bcd: LVL_DIGIT must be below DIGITS");
    end

    logic [NCH-1:0]  hit_q;
    logic [NCH-1:0]  rise;
    logic [3:0]      inc;
    logic [3:0]      net;
    logic            dec;
    logic            add_go;
    logic            sub_go;
    logic [W-1:0]    score_q, score_d;
    logic [W-1:0]    hiscore_q, hiscore_d;
    logic [W-1:0]    add_res;
    logic [W-1:0]    sub_res;
    logic [DIGITS:0] carry;
    logic [DIGITS:0] borrow;
    logic [4:0]      dsum;
    logic [3:0]      addend;
    logic            level_up_q, level_up_d;
    logic            new_hi_q, new_hi_d;
    logic            score_max;

    // Hit edge detection and per-cycle net point count.
    always_comb begin
        rise = hit & ~hit_q;
        inc  = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            inc = inc + {3'b000, rise[i]};
        end
        dec    = miss & en;
        net    = inc - {3'b000, dec};
        add_go = en && (inc > {3'b000, dec});
        sub_go = dec && (inc == 4'd0);
    end

    // Digit 0 absorbs the whole 0..9 increment; higher digits only see a carry.
    always_comb begin
        carry    = '0;
        carry[0] = add_go;
        add_res  = '0;
        dsum     = '0;
        addend   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            addend = (i == 0) ? net : {3'b000, carry[i]};
            dsum   = {1'b0, score_q[4*i +: 4]} + {1'b0, addend};
            if (dsum >= 5'd10) begin
                add_res[4*i +: 4] = dsum[3:0] + 4'd6;
                carry[i+1]        = 1'b1;
            end else begin
                add_res[4*i +: 4] = dsum[3:0];
                carry[i+1]        = 1'b0;
            end
        end
    end

    // A borrow out of the top digit means the score was already zero.
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        sub_res   = score_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow[i]) begin
                if (score_q[4*i +: 4] == 4'd0) begin
                    sub_res[4*i +: 4] = 4'd9;
                    borrow[i+1]       = 1'b1;
                end else begin
                    sub_res[4*i +: 4] = score_q[4*i +: 4] - 4'd1;
                    borrow[i+1]       = 1'b0;
                end
            end
        end
    end

    assign score_max = (score_q == MaxScore);

    always_comb begin
        score_d    = score_q;
        hiscore_d  = hiscore_q;
        level_up_d = 1'b0;
        new_hi_d   = 1'b0;
        if (game_end) begin
            score_d = '0;
            // Packed BCD with legal digits orders the same as plain binary.
            if (score_q > hiscore_q) begin
                hiscore_d = score_q;
                new_hi_d  = 1'b1;
            end
        end else if (add_go) begin
            score_d    = carry[DIGITS] ? MaxScore : add_res;
            level_up_d = (|(carry & LvlMask)) && !score_max;
        end else if (sub_go && !borrow[DIGITS]) begin
            score_d = sub_res;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hit_q      <= '0;
            score_q    <= '0;
            hiscore_q  <= '0;
            level_up_q <= 1'b0;
            new_hi_q   <= 1'b0;
        end else begin
            hit_q      <= hit;
            score_q    <= score_d;
            hiscore_q  <= hiscore_d;
            level_up_q <= level_up_d;
            new_hi_q   <= new_hi_d;
        end
    end

    assign score    = score_q;
    assign hiscore  = hiscore_q;
    assign level_up = level_up_q;
    assign new_hi   = new_hi_q;
    assign sat      = score_max;

`ifndef SYNTHESIS
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_bcd_legal
        a_score_digit : assert property (@(posedge clk) disable iff (clr)
            score_q[4*g +: 4] <= 4'd9);
        a_hiscore_digit : assert property (@(posedge clk) disable iff (clr)
            hiscore_q[4*g +: 4] <= 4'd9);
    end
`endif

endmodule

// File: doc/wam_score_bcd.md
# wam_score_bcd

Parametrised, fully synchronous BCD score unit for the Whac-A-Mole datapath. It sits between the per-hole hit detectors and the seven-segment display driver. It replaces ripple-clocked digit counters with one clocked multi-digit BCD accumulator that handles several hits per cycle, a miss penalty, saturation, level-up pulses and a high-score register.

## Interface

Parameters:
- NCH, 8, number of hit channels (legal 1..9, so one cycle's increment fits in one BCD digit)
- DIGITS, 3, number of BCD digits in score and hiscore (legal 1..6)
- LVL_DIGIT, 1, digit index whose increment raises level_up (1 = every 10 points; legal 0..DIGITS-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-high
- en  in  1  scoring enable; when low, hit and miss edges are tracked but not scored
- hit  in  NCH  per-hole hit levels; each rising edge scores one point
- miss  in  1  single-cycle penalty pulse, −1 point
- game_end  in  1  single-cycle end-of-game pulse
- score  out  4*DIGITS  current score, BCD, digit 0 in bits [3:0]
- hiscore  out  4*DIGITS  best completed-game score, BCD
- level_up  out  1  one-cycle pulse when score crosses a multiple of 10^LVL_DIGIT upward
- sat  out  1  high while score equals the all-9s maximum
- new_hi  out  1  one-cycle pulse when game_end updates hiscore

## Operation

- hit_q register holds the previous sample of hit. rise = hit & ~hit_q. hit_q updates every cycle regardless of en.
- inc = popcount(rise), range 0..NCH. net = inc − (miss & en).
- Score update per cycle when en=1 and game_end=0:
  - net > 0: BCD add with per-digit decimal carry. If the result exceeds 10^DIGITS−1, clamp to all 9s.
  - net = −1: BCD decrement with borrow. At 0, score stays 0 (floor).
  - net = 0, including one hit plus a miss in the same cycle: score holds.
- level_up = 1 for one cycle when the value floor(score/10^LVL_DIGIT) strictly increases across an update, including an increase that ends at the saturation clamp.
  - A multi-point add crossing two boundaries still gives one pulse.
  - A decrement never pulses.
- sat is combinational from the score register: 1 iff every digit = 9.
- game_end (has priority over hit and miss in the same cycle):
  - If score > hiscore (unsigned BCD compare), load hiscore := score and pulse new_hi.
  - score := 0 in all cases.
  - level_up = 0.
  - Hits and misses in that cycle are discarded; hit_q still updates.
- en=0: score, level_up and new_hi are unaffected by hits or misses. game_end still acts.
- Only legal BCD digits (0..9) ever appear on score and hiscore.

## Timing

- Reset values while clr=1: score=0, hiscore=0, hit_q=0, level_up=0, new_hi=0, sat=0. Assertion takes effect immediately; deassertion is synchronous-safe. A hit held high through reset release scores one point on the first clock edge after release.
- Latency: a hit first sampled high at edge k updates score at edge k; the new value is visible after edge k. level_up and new_hi are registered and assert in the same cycle as the score update they belong to.
- A held hit scores once only. It must go low for at least one sampled cycle before it can score again.
- miss is level-sampled every cycle. Holding it high for N cycles costs N points.
- Worst case of one BCD add of 0..9 across DIGITS digits must close timing at the board clock. No multicycle paths.

## Test plan

- Reset then single hits: clr pulse; hit[0] rising edges ×12 at 1 per 3 cycles -> score=0x012; level_up exactly once, on the 10th hit; sat=0.
- Simultaneous hits: from score=0x008, assert hit=8'hFF for one cycle -> score=0x016 next cycle; single level_up pulse. Holding hit=8'hFF for 5 more cycles adds nothing.
- Miss and floor: score=0x001; miss ×3 cycles -> score 0x000 after the first, stays 0x000; no level_up. In one cycle, one hit plus miss -> score unchanged.
- Saturation: preload to 0x995 via hits; a cycle with 7 hit rises -> score=0x999, sat=1, level_up=1. A further hit holds 0x999. Then miss -> 0x998, sat=0.
- Game end and high score: score=0x042, hiscore=0 -> game_end: hiscore=0x042, new_hi pulse, score=0. Next game reaches 0x030 -> game_end: hiscore stays 0x042, no new_hi. A hit in the same cycle as game_end is ignored.
- Enable and async reset: en=0 with hits and misses -> score frozen. Assert clr between clock edges at score=0x057 -> all outputs 0 immediately; hiscore cleared.
